// File: rtl/spi_reg_bridge_pkg.sv
// Shared types and constants for the SPI register bridge.
// Optional write lock is enabled by defining SPI_REG_BRIDGE_WRLOCK_EN.
package spi_reg_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WRITE = 2'd2,
    READ  = 2'd3
  } state_e;

  localparam int         RD_BIT   = 7;
  localparam logic [6:0] ID_ADDR  = 7'h7F;
  localparam logic [7:0] LOCK_KEY = 8'hA5;

  // 7-bit address step; wraps 7'h7F -> 7'h00
  function automatic logic [6:0] addr_inc(input logic [6:0] a);
    return a + 7'd1;
  endfunction

endpackage

// File: rtl/spi_reg_bridge_reg_bank.sv
// Register array with write decode, one-cycle write strobes and a read mux.
// With SPI_REG_BRIDGE_WRLOCK_EN the top register gates writes to all others.
module spi_reg_bank
  import spi_reg_bridge_pkg::*;
#(
  parameter int         N_REGS  = 16,
  parameter logic [7:0] DEV_ID  = 8'h5A,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                wr_en,
  input  logic [6:0]          wr_addr,
  input  logic [7:0]          wr_data,
  input  logic [6:0]          rd_addr,
  output logic [7:0]          rd_data,
  output logic [N_REGS*8-1:0] regs_q,
  output logic [N_REGS-1:0]   wr_strobe
);

  logic [7:0]        regs_reg [N_REGS];
  logic [N_REGS-1:0] hit_vec;
  logic [N_REGS-1:0] wr_strobe_reg;
  logic              wr_allow;

`ifdef SPI_REG_BRIDGE_WRLOCK_EN
  localparam logic [6:0] LOCK_ADDR = 7'(N_REGS - 1);
  // The lock register stays writable so a locked bank can always be reopened
  assign wr_allow = (wr_addr == LOCK_ADDR) || (regs_reg[N_REGS-1] == LOCK_KEY);
`else
  assign wr_allow = 1'b1;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N_REGS; gi++) begin : g_reg
      localparam logic [6:0] REG_ADDR = 7'(gi);

      assign hit_vec[gi] = wr_en && wr_allow && (wr_addr == REG_ADDR);

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          regs_reg[gi] <= RST_VAL;
        end else if (hit_vec[gi]) begin
          regs_reg[gi] <= wr_data;
        end
      end

      assign regs_q[8*gi +: 8] = regs_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_strobe_reg <= '0;
    end else begin
      wr_strobe_reg <= hit_vec;
    end
  end

  assign wr_strobe = wr_strobe_reg;

  always_comb begin
    rd_data = 8'h00;
    if (rd_addr == ID_ADDR) begin
      rd_data = DEV_ID;
    end
    for (int i = 0; i < N_REGS; i++) begin
      if (rd_addr == 7'(i)) begin
        rd_data = regs_reg[i];
      end
    end
  end

endmodule

// File: rtl/spi_reg_bridge.sv
// Byte-level SPI command decoder: csn sync, frame FSM, auto-increment address, tx byte.
// Optional write lock (SPI_REG_BRIDGE_WRLOCK_EN) lives in spi_reg_bank.
module spi_reg_bridge
  import spi_reg_bridge_pkg::*;
#(
  parameter int         N_REGS  = 16,
  parameter logic [7:0] DEV_ID  = 8'h5A,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                csn,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  input  logic                tx_req,
  output logic [7:0]          tx_data,
  output logic [N_REGS*8-1:0] regs_q,
  output logic [N_REGS-1:0]   wr_strobe,
  output logic                busy
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_CMD   = CMD;
  localparam logic [1:0] S_WRITE = WRITE;
  localparam logic [1:0] S_READ  = READ;

  logic [1:0] csn_sync_reg;
  logic       csn_d_reg;
  logic       csn_s;
  logic       csn_fall;

  logic [1:0] state_reg, state_next;
  logic [6:0] addr_reg, addr_next;
  logic [7:0] tx_data_reg, tx_data_next;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic       wr_en;

  assign csn_s    = csn_sync_reg[1];
  assign csn_fall = csn_d_reg & ~csn_s;

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    tx_data_next = tx_data_reg;
    rd_addr      = addr_reg;
    wr_en        = 1'b0;

    case (state_reg)
      S_IDLE: begin
        tx_data_next = DEV_ID;
        if (csn_fall) begin
          state_next = S_CMD;
        end
      end
      S_CMD: begin
        if (rx_valid) begin
          addr_next    = rx_data[6:0];
          rd_addr      = rx_data[6:0];
          tx_data_next = rd_data;
          state_next   = rx_data[RD_BIT] ? S_READ : S_WRITE;
        end
      end
      S_WRITE: begin
        if (rx_valid) begin
          wr_en     = 1'b1;
          addr_next = addr_inc(addr_reg);
        end
      end
      default: begin
        if (tx_req) begin
          addr_next    = addr_inc(addr_reg);
          rd_addr      = addr_inc(addr_reg);
          tx_data_next = rd_data;
        end
      end
    endcase

    // Deselect wins over everything except a write already accepted this cycle
    if (csn_s) begin
      state_next   = S_IDLE;
      addr_next    = addr_reg;
      tx_data_next = DEV_ID;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      csn_sync_reg <= 2'b11;
      csn_d_reg    <= 1'b1;
      state_reg    <= S_IDLE;
      addr_reg     <= 7'd0;
      tx_data_reg  <= DEV_ID;
    end else begin
      csn_sync_reg <= {csn_sync_reg[0], csn};
      csn_d_reg    <= csn_sync_reg[1];
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      tx_data_reg  <= tx_data_next;
    end
  end

  spi_reg_bank #(
    .N_REGS  (N_REGS),
    .DEV_ID  (DEV_ID),
    .RST_VAL (RST_VAL)
  ) u_bank (
    .clk       (clk),
    .rstn      (rstn),
    .wr_en     (wr_en),
    .wr_addr   (addr_reg),
    .wr_data   (rx_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .regs_q    (regs_q),
    .wr_strobe (wr_strobe)
  );

  assign tx_data = tx_data_reg;
  assign busy    = (state_reg != S_IDLE);

endmodule
